fetch_stage: RTL and testbench

- Instruction fetch stage of the SCC core. It sits between instruction memory and the decode stage.
- Owns the PC. Issues word addresses to the synchronous instruction memory.
- Buffers returned words with their PCs in a 2-entry prefetch FIFO.
- Presents them to decode over a valid/ready handshake.
- Accepts branch redirects from execute and a halt request.

---
 rtl/scc_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scc_pkg
// Description : Shared types and constants for the SCC core fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package scc_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Branch targets are word aligned; the low two address bits carry no meaning.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : BUF_DEPTH-entry prefetch FIFO of {pc, instr}; flush beats push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import scc_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_push,
    input  logic                               i_pop,
    input  logic                               i_flush,
    input  fetch_entry_t                       i_wdata,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     o_count,
    output fetch_entry_t                       o_head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_entry_t       r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : SCC instruction fetch: PC, memory requests, prefetch buffer,
//               redirect/halt handling. Define FETCH_PERF_EN for perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import scc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] in_mem,
    output logic [ADDR_W-1:0]  in_mem_addr,
    output logic               in_mem_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;

    logic [CNT_W-1:0]   w_count;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic               w_pop;
    logic               w_issue;
    logic [OCC_W-1:0]   w_occupancy;
    logic [ADDR_W-1:0]  w_redirect_target;

    assign w_pop             = instr_valid & instr_ready;
    assign w_redirect_target = align_word(redirect_pc);

    // Slots committed after this cycle: buffered + returning - leaving.
    assign w_occupancy = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign w_issue     = (r_state == RUN) & ~redirect_valid & ~halt_req
                       & (w_occupancy < OCC_W'(BUF_DEPTH));

    assign in_mem_en    = w_issue;
    assign in_mem_addr  = r_fetch_pc;
    assign w_push_entry = '{pc: r_inflight_pc, instr: in_mem};

    // A redirect flushes at the end of its cycle; flush priority drops the
    // response landing that cycle, and no request was issued alongside it.
    fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_push_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign instr_valid = (w_count != '0);
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight    <= w_issue;
            r_inflight_pc <= r_fetch_pc;

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_target;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + PC_INC;
            end

            case (r_state)
                IDLE:    r_state <= RUN;
                RUN:     if (halt_req && !redirect_valid) r_state <= HALTED;
                HALTED:  if (redirect_valid) r_state <= RUN;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (r_state == RUN) & ~w_issue & ~redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_pop);
            r_perf_stall   <= r_perf_stall + 32'(w_stall);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Randomized bench for fetch_stage against a transaction model;
//               two instances (RESET_PC 0/depth 2 and FFFF_FFF8/depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam int NI     = 2;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;

    logic [31:0] mem0, mem1, addr0, addr1, word0, word1, pc0, pc1;
    logic        en0, en1, val0, val1;
`ifdef FETCH_PERF_EN
    logic [31:0] pf0, pf1, ps0, ps1;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut0 (
        .clk(clk), .reset(reset), .in_mem(mem0), .in_mem_addr(addr0), .in_mem_en(en0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .instr_valid(val0), .instr(word0), .instr_pc(pc0), .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf0), .perf_stall(ps0)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .in_mem(mem1), .in_mem_addr(addr1), .in_mem_en(en1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .instr_valid(val1), .instr(word1), .instr_pc(pc1), .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf1), .perf_stall(ps1)
`endif
    );

    // Synchronous instruction memory: word for address A is A ^ KEY, one cycle later.
    always @(posedge clk) begin
        mem0 <= addr0 ^ KEY;
        mem1 <= addr1 ^ KEY;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input int k, input string s);
        return $sformatf("u%0d.%s@%0d", k, s, cyc);
    endfunction

    // Reference model: PC stream, buffered PCs in order, one outstanding request.
    int          st      [NI];
    logic [31:0] mpc     [NI];
    logic [31:0] mfifo   [NI][8];
    int          mcnt    [NI];
    bit          minfl   [NI];
    logic [31:0] minfl_pc[NI];
    logic [31:0] mperf_f [NI];
    logic [31:0] mperf_s [NI];

    function automatic int depth_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] reset_pc_of(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    endfunction

    task automatic model_reset(input int k);
        st[k]       = M_IDLE;
        mpc[k]      = reset_pc_of(k);
        mcnt[k]     = 0;
        minfl[k]    = 1'b0;
        minfl_pc[k] = '0;
        mperf_f[k]  = '0;
        mperf_s[k]  = '0;
    endtask

    task automatic step();
        logic [31:0] o_addr, o_word, o_pc, hpc, old_pc;
        logic        o_en, o_val;
        bit          v, pop, en, stall;
        int          occ;
        #2;
        for (int k = 0; k < NI; k++) begin
            if (k == 0) begin
                o_addr = addr0; o_word = word0; o_pc = pc0; o_en = en0; o_val = val0;
            end else begin
                o_addr = addr1; o_word = word1; o_pc = pc1; o_en = en1; o_val = val1;
            end
            if (reset) model_reset(k);

            v     = (mcnt[k] > 0);
            hpc   = v ? mfifo[k][0] : 32'h0;
            pop   = v && instr_ready;
            occ   = mcnt[k] + int'(minfl[k]) - int'(pop);
            en    = (st[k] == M_RUN) && !redirect_valid && !halt_req && (occ < depth_of(k));
            stall = (st[k] == M_RUN) && !en && !redirect_valid;

            check_eq(tg(k, "instr_valid"), 32'(o_val), 32'(v));
            check_eq(tg(k, "in_mem_en"), 32'(o_en), 32'(en));
            check_eq(tg(k, "in_mem_addr"), o_addr, mpc[k]);
            if (v) begin
                check_eq(tg(k, "instr_pc"), o_pc, hpc);
                check_eq(tg(k, "instr"), o_word, hpc ^ KEY);
            end
            if (reset) begin
                check_eq(tg(k, "rst_instr"), o_word, 32'h0);
                check_eq(tg(k, "rst_instr_pc"), o_pc, 32'h0);
            end
`ifdef FETCH_PERF_EN
            check_eq(tg(k, "perf_fetched"), (k == 0) ? pf0 : pf1, mperf_f[k]);
            check_eq(tg(k, "perf_stall"), (k == 0) ? ps0 : ps1, mperf_s[k]);
`endif
            if (!reset) begin
                old_pc = mpc[k];
                if (pop) begin
                    for (int j = 0; j < 7; j++) mfifo[k][j] = mfifo[k][j+1];
                    mcnt[k]--;
                end
                if (redirect_valid) begin
                    mcnt[k] = 0;
                    mpc[k]  = redirect_pc & ~32'h3;
                end else begin
                    if (minfl[k] && mcnt[k] < 8) begin
                        mfifo[k][mcnt[k]] = minfl_pc[k];
                        mcnt[k]++;
                    end
                    if (en) mpc[k] = mpc[k] + 32'd4;
                end
                minfl[k]    = en;
                minfl_pc[k] = old_pc;
                case (st[k])
                    M_IDLE:  st[k] = M_RUN;
                    M_RUN:   if (halt_req && !redirect_valid) st[k] = M_HALT;
                    default: if (redirect_valid) st[k] = M_RUN;
                endcase
                mperf_f[k] = mperf_f[k] + 32'(pop);
                mperf_s[k] = mperf_s[k] + 32'(stall);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic redirect_to(input logic [31:0] target, input bit with_halt);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        halt_req       = with_halt;
        step();
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        @(negedge clk);
        repeat (2) step();
        reset = 1'b0;

        // Streaming start, then a decode stall and recovery.
        repeat (8) step();
        instr_ready = 1'b0;
        repeat (6) step();
        instr_ready = 1'b1;
        repeat (6) step();

        // Redirect with a full buffer.
        instr_ready = 1'b0;
        repeat (4) step();
        redirect_to(32'h0000_0103, 1'b0);
        instr_ready = 1'b1;
        repeat (6) step();

        // Halt pulse, drain, resume, then halt colliding with redirect.
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        repeat (6) step();
        redirect_to(32'h0000_0040, 1'b0);
        repeat (5) step();
        redirect_to(32'h0000_0200, 1'b1);
        repeat (5) step();

        // Address wrap through the top of the space.
        redirect_to(32'hFFFF_FFF2, 1'b0);
        repeat (8) step();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            halt_req       = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom);
            step();
        end

        // Asynchronous reset with a request outstanding.
        instr_ready = 1'b1;
        redirect_to(32'h0000_1000, 1'b0);
        for (int i = 0; i < 20 && !minfl[0]; i++) step();
        repeat (3) step();
        check_eq("inflight_before_reset", 32'(minfl[0]), 32'h1);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (25) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
